elevator_scheduler: RTL

Sequences one elevator car against the pending-stop vectors produced by the floor-selection logic. Implements SCAN dispatch: keep travelling in the current direction while stops remain ahead, then reverse. Times floor-to-floor travel and the door dwell, and emits a one-cycle service pulse so the selection logic can clear the served stop. Sits between the request-collection block and the car drive/door actuators.

---
 rtl/elevator_pkg.sv | 16 +
 rtl/floor_scan.sv | 29 ++
 rtl/elevator_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg
//   Shared definitions for the elevator control blocks (floor selection,
//   scheduler, display). It holds the car state encoding and the default
//   shaft geometry.
package elevator_pkg;

   localparam int FLOOR_W      = 5;
   localparam int N_FLOORS_DEF = 20;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DOOR = 2'd2
   } state_t;

endpackage

// File: rtl/floor_scan.sv
// floor_scan
//   Combinational look-around for the SCAN dispatcher. It reports whether any
//   pending stop lies strictly above or strictly below a given floor.
//   Ports:
//     pending   in  N_FLOORS  pending stops, bit i = floor i
//     floor     in  FLOOR_W   reference floor
//     any_above out 1         a pending bit exists at index > floor
//     any_below out 1         a pending bit exists at index < floor
module floor_scan #(
   parameter int N_FLOORS = 20,
   parameter int FLOOR_W  = 5
) (
   input  logic [N_FLOORS-1:0] pending,
   input  logic [FLOOR_W-1:0]  floor,
   output logic                any_above,
   output logic                any_below
);

   // Masked OR-reduce. The reference floor itself falls in neither mask.
   always_comb begin
      any_above = 1'b0;
      any_below = 1'b0;
      for (int i = 0; i < N_FLOORS; i++) begin
         if (FLOOR_W'(i) > floor) any_above = any_above | pending[i];
         if (FLOOR_W'(i) < floor) any_below = any_below | pending[i];
      end
   end

endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler
//   SCAN dispatcher for one elevator car. The car keeps moving in its current
//   direction while stops remain ahead, and reverses when none are left.
//   The block times the floor-to-floor travel and the door dwell. It pulses
//   'served' once on each door opening so that the selection logic can clear
//   the stop it has just served.
//   Ports:
//     clk, reset    clock; synchronous active-high reset
//     dest_up       pending stops for upward service (bit i = floor i)
//     dest_down     pending stops for downward service
//     door_hold     while high in DOOR, the dwell restarts at full length
//     floor         current car floor
//     dir_up        current or last travel direction (1 = up)
//     moving        high while in MOVE
//     door_open     high while in DOOR
//     served        one-cycle pulse on entry to DOOR
//     served_floor  floor served; updated together with served
module elevator_scheduler #(
   parameter int N_FLOORS     = elevator_pkg::N_FLOORS_DEF,
   parameter int FLOOR_W      = elevator_pkg::FLOOR_W,
   parameter int TRAVEL_TICKS = 8,
   parameter int DOOR_TICKS   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_FLOORS-1:0] dest_up,
   input  logic [N_FLOORS-1:0] dest_down,
   input  logic                door_hold,
   output logic [FLOOR_W-1:0]  floor,
   output logic                dir_up,
   output logic                moving,
   output logic                door_open,
   output logic                served,
   output logic [FLOOR_W-1:0]  served_floor
);

   import elevator_pkg::*;

   localparam int TCNT_W = $clog2(TRAVEL_TICKS + 1);
   localparam int DCNT_W = $clog2(DOOR_TICKS + 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);
   localparam logic [TCNT_W-1:0]  TRAVEL_LOAD = TCNT_W'(TRAVEL_TICKS - 1);
   localparam logic [DCNT_W-1:0]  DOOR_LOAD   = DCNT_W'(DOOR_TICKS - 1);

   state_t              state;
   logic [TCNT_W-1:0]   travel_cnt;   // travel cycles left after this one
   logic [DCNT_W-1:0]   dwell_cnt;    // door cycles left after this one
   logic [N_FLOORS-1:0] pending;
   logic [FLOOR_W-1:0]  step_floor;
   logic [FLOOR_W-1:0]  eval_floor;
   logic                arrive;
   logic                any_above;
   logic                any_below;
   logic                stop_here;
   logic                ahead;
   logic                behind;

   assign pending = dest_up | dest_down;

   // Neighbour floor in the travel direction, clamped to the ends of the shaft.
   always_comb begin
      step_floor = floor;
      if (dir_up) begin
         if (floor != TOP_FLOOR) step_floor = floor + 1'b1;
      end else if (floor != '0) begin
         step_floor = floor - 1'b1;
      end
   end

   // On the last travel cycle every decision refers to the floor being
   // reached. In all other cycles it refers to the current floor. This lets a
   // single scan instance serve both IDLE dispatch and the arrival check.
   assign arrive     = (state == MOVE) && (travel_cnt == '0);
   assign eval_floor = arrive ? step_floor : floor;

   floor_scan #(
      .N_FLOORS (N_FLOORS),
      .FLOOR_W  (FLOOR_W)
   ) u_scan (
      .pending   (pending),
      .floor     (eval_floor),
      .any_above (any_above),
      .any_below (any_below)
   );

   // A call for the opposite direction is taken only when nothing lies
   // further ahead, so that the car turns around at that floor.
   assign stop_here = dir_up ? (dest_up[eval_floor]   | (dest_down[eval_floor] & ~any_above))
                             : (dest_down[eval_floor] | (dest_up[eval_floor]   & ~any_below));
   assign ahead     = dir_up ? any_above : any_below;
   assign behind    = dir_up ? any_below : any_above;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         floor        <= '0;
         dir_up       <= 1'b1;
         moving       <= 1'b0;
         door_open    <= 1'b0;
         served       <= 1'b0;
         served_floor <= '0;
         travel_cnt   <= '0;
         dwell_cnt    <= '0;
      end else begin
         served <= 1'b0;
         case (state)
            IDLE: begin
               if (pending[floor]) begin
                  state        <= DOOR;
                  door_open    <= 1'b1;
                  served       <= 1'b1;
                  served_floor <= floor;
                  dwell_cnt    <= DOOR_LOAD;
               end else if (any_above && (dir_up || !any_below)) begin
                  // If stops are pending on both sides, keep the current direction.
                  dir_up     <= 1'b1;
                  state      <= MOVE;
                  moving     <= 1'b1;
                  travel_cnt <= TRAVEL_LOAD;
               end else if (any_below) begin
                  dir_up     <= 1'b0;
                  state      <= MOVE;
                  moving     <= 1'b1;
                  travel_cnt <= TRAVEL_LOAD;
               end
            end
            MOVE: begin
               if (travel_cnt != '0) begin
                  travel_cnt <= travel_cnt - 1'b1;
               end else begin
                  floor      <= step_floor;
                  travel_cnt <= TRAVEL_LOAD;
                  if (stop_here) begin
                     state        <= DOOR;
                     moving       <= 1'b0;
                     door_open    <= 1'b1;
                     served       <= 1'b1;
                     served_floor <= step_floor;
                     dwell_cnt    <= DOOR_LOAD;
                  end else if (!ahead) begin
                     if (behind) begin
                        dir_up <= ~dir_up;
                     end else begin
                        state  <= IDLE;
                        moving <= 1'b0;
                     end
                  end
               end
            end
            DOOR: begin
               if (door_hold) begin
                  dwell_cnt <= DOOR_LOAD;
               end else if (dwell_cnt != '0) begin
                  dwell_cnt <= dwell_cnt - 1'b1;
               end else begin
                  state     <= IDLE;
                  door_open <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               moving    <= 1'b0;
               door_open <= 1'b0;
            end
         endcase
      end
   end

endmodule
